word_lane_scheduler: RTL and testbench
======================================

# word_lane_scheduler

- Round-robin scheduler that shares one 8-bit byte lane between N_REQ 32-bit word sources.
- Sequences each granted word out as four bytes, MSB first, with a per-byte valid. It does the job of the word32→8-bit serializer for multiple requesters.
- Sits in the clk_4f domain, between the word producers and the 8-bit→32-bit deserializer / byte link. Tags every byte with its source lane and a start-of-word marker.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- WORD_W, 32, input word width; fixed ratio WORD_W = 4 × BYTE_W
- BYTE_W, 8, output lane width
- CNT_W, 16, width of the accepted-word counter

Ports:
- clk_4f  in  1  byte-rate clock; one clock only
- reset  in  1  synchronous, active-high
- valid_in  in  N_REQ  bit i: requester i presents a word
- Data_in  in  WORD_W×N_REQ  requester i word at [WORD_W*i +: WORD_W]
- port_en  in  N_REQ  bit i=0 masks requester i from arbitration
- ready_out  out  N_REQ  one-hot grant; word i accepted when valid_in[i] & ready_out[i]
- valid_out  out  1  byte on Data_out is valid
- Data_out  out  BYTE_W  current byte
- lane_id  out  clog2(N_REQ)  source requester of the current byte
- sof  out  1  high on byte 0 of each word
- word_count  out  CNT_W  number of accepted words, wraps

## Operation
- States:
  - IDLE: no word in flight.
  - SEND: shifting a latched word; byte_cnt counts 0..3.
- Accept slot: the block can accept a word when state = IDLE, or when state = SEND and byte_cnt = 3. This gives zero-bubble back-to-back words.
- Arbitration:
  - Eligible requesters: valid_in & port_en.
  - Winner: first eligible index searching upward from last_grant+1, modulo N_REQ.
  - ready_out is combinational: one-hot on the winner in an accept slot, else all zero.
- On accept:
  - Latch the word into a shift register, lane_id ← winner, last_grant ← winner.
  - word_count ← word_count+1, wrapping at 2^CNT_W.
  - Next state SEND, byte_cnt ← 0.
- In SEND:
  - Data_out = sr[WORD_W-1 -: BYTE_W].
  - Shift left by BYTE_W each cycle; byte_cnt increments.
  - sof = (byte_cnt == 0).
- At byte_cnt = 3 with no accept: next state IDLE.
- Masking (port_en deassert) only affects future arbitration. A word in flight always completes.
- Requesters hold valid_in and Data_in stable until accepted. The scheduler never drops or duplicates an accepted word.

## Timing
- Reset values: state IDLE, byte_cnt 0, last_grant N_REQ-1 (so requester 0 has first priority), valid_out 0, Data_out 0, lane_id 0, sof 0, word_count 0, ready_out all 0 while reset = 1.
- Latency: accept at edge k → byte 0 valid in cycle k+1, byte 3 in cycle k+4.
- Throughput: one word per 4 clk_4f cycles under continuous demand.
- Gaps: valid_out is continuous across back-to-back words, with no idle cycle between them.
- IDLE outputs: valid_out = 0, sof = 0, Data_out = 0; lane_id holds its last value.
- Reset mid-word: aborts the word in flight. valid_out = 0 from the cycle after reset is sampled; no residual bytes appear after reset.
- All requesters valid: each is granted exactly once per N_REQ words.
- Only the last granted requester valid: it is granted again with no bubble.
- port_en all zero: no accept. The block drains its current word, then stays in IDLE.

## Structure
- Shared package holds BYTES_PER_WORD = 4, the state encoding (ST_IDLE, ST_SEND) and the byte_cnt width.
- Sub-module rr_arbiter (parameter N_REQ):
  - Inputs: req, last_grant.
  - Outputs: one-hot gnt, encoded gnt_idx, any.
  - Purely combinational; reused by other lane schedulers.
- Top-level contents: FSM, shift register, byte_cnt, last_grant, counter.

## Test plan
- Reset then single word: valid_in = 0001, Data_in[31:0] = 32'hA1B2C3D4, accepted at edge k.
  - Bytes A1, B2, C3, D4 in cycles k+1..k+4.
  - sof only on A1; lane_id = 0; word_count = 1.
- All four requesters valid continuously, words 0x11111111·(i+1).
  - Grant order 0,1,2,3,0 with no gap in valid_out.
  - 16 consecutive valid bytes; word_count = 4 after the first four words.
- Mask: port_en = 1011, all valid.
  - Requester 2 never granted; order 0,1,3,0.
  - Clearing port_en[0] while word 0 is in flight still sends all 4 of its bytes.
- Reset asserted after byte 1 (B2) of 0xA1B2C3D4: valid_out = 0 the next cycle; C3 and D4 never appear; word_count = 0.
- Counter wrap with CNT_W = 4: 17 accepted words → word_count = 1.
- Gap: requester 1 valid only every 10 cycles.
  - State returns to IDLE between words; valid_out low for 6 cycles between words; ready_out stays 0 when nothing is valid.

Source files
------------

// File: rtl/word_lane_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : word_lane_scheduler_pkg
// Description : Shared constants for the word-to-byte lane schedulers.
// Revision    : 1.0 - initial release
// ============================================================================
package word_lane_scheduler_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

endpackage : word_lane_scheduler_pkg
`default_nettype wire

// File: rtl/word_lane_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter, search starts after last_grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    int w_cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_cand  = 0;
        // Offsets 1..N_REQ so the last winner is considered last.
        for (int off = 1; off <= N_REQ; off++) begin
            w_cand = (int'(last_grant) + off) % N_REQ;
            if (!any && req[w_cand]) begin
                any          = 1'b1;
                gnt[w_cand]  = 1'b1;
                gnt_idx      = IDX_W'(w_cand);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/word_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : word_lane_scheduler
// Description : Round-robin shares one byte lane among N_REQ word sources, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module word_lane_scheduler
    import word_lane_scheduler_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk_4f,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        valid_in,
    input  logic [WORD_W*N_REQ-1:0] Data_in,
    input  logic [N_REQ-1:0]        port_en,
    output logic [N_REQ-1:0]        ready_out,
    output logic                    valid_out,
    output logic [BYTE_W-1:0]       Data_out,
    output logic [IDX_W-1:0]        lane_id,
    output logic                    sof,
    output logic [CNT_W-1:0]        word_count
);

    localparam logic [BCNT_W-1:0] c_last_byte = BCNT_W'(BYTES_PER_WORD - 1);

    logic [0:0]        r_state;
    logic [BCNT_W-1:0] r_byte_cnt;
    logic [WORD_W-1:0] r_sr;
    logic [IDX_W-1:0]  r_last_grant;
    logic [IDX_W-1:0]  r_lane_id;
    logic [CNT_W-1:0]  r_word_count;

    logic [N_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]  w_gnt_idx;
    logic              w_any;
    logic              w_slot;
    logic              w_accept;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req        (valid_in & port_en),
        .last_grant (r_last_grant),
        .gnt        (w_gnt),
        .gnt_idx    (w_gnt_idx),
        .any        (w_any)
    );

    // Accepting on the last byte keeps back-to-back words bubble-free.
    assign w_slot    = (r_state == ST_IDLE) || (r_byte_cnt == c_last_byte);
    assign w_accept  = w_slot && w_any && !reset;
    assign ready_out = (w_slot && !reset) ? w_gnt : '0;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_byte_cnt   <= '0;
            r_sr         <= '0;
            r_last_grant <= IDX_W'(N_REQ - 1);
            r_lane_id    <= '0;
            r_word_count <= '0;
        end else if (w_accept) begin
            r_sr         <= Data_in[WORD_W*w_gnt_idx +: WORD_W];
            r_lane_id    <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
            r_word_count <= r_word_count + CNT_W'(1);
            r_state      <= ST_SEND;
            r_byte_cnt   <= '0;
        end else if (r_state == ST_SEND) begin
            if (r_byte_cnt == c_last_byte) begin
                r_state    <= ST_IDLE;
                r_byte_cnt <= '0;
            end else begin
                r_sr       <= r_sr << BYTE_W;
                r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
            end
        end
    end

    assign valid_out  = (r_state == ST_SEND);
    assign Data_out   = (r_state == ST_SEND) ? r_sr[WORD_W-1 -: BYTE_W] : '0;
    assign sof        = (r_state == ST_SEND) && (r_byte_cnt == '0);
    assign lane_id    = r_lane_id;
    assign word_count = r_word_count;

endmodule : word_lane_scheduler
`default_nettype wire

// File: tb/tb_word_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_word_lane_scheduler
// Description : Directed self-checking bench for word_lane_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_word_lane_scheduler;

    logic         clk_4f = 1'b0;
    logic         reset;
    logic [3:0]   valid_in;
    logic [127:0] Data_in;
    logic [3:0]   port_en;
    logic [3:0]   ready_out;
    logic         valid_out;
    logic [7:0]   Data_out;
    logic [1:0]   lane_id;
    logic         sof;
    logic [3:0]   word_count;

    int errors = 0;
    int checks = 0;

    word_lane_scheduler #(
        .N_REQ  (4),
        .WORD_W (32),
        .BYTE_W (8),
        .CNT_W  (4)
    ) dut (
        .clk_4f     (clk_4f),
        .reset      (reset),
        .valid_in   (valid_in),
        .Data_in    (Data_in),
        .port_en    (port_en),
        .ready_out  (ready_out),
        .valid_out  (valid_out),
        .Data_out   (Data_out),
        .lane_id    (lane_id),
        .sof        (sof),
        .word_count (word_count)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic tick();
        @(posedge clk_4f);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        valid_in = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Checks the four bytes of one word; ready_out is checked in the last-byte slot.
    task automatic send_word(input string tag, input int g, input logic [31:0] w,
                             input logic [3:0] cnt, input logic [3:0] next_ready,
                             input bit stop, input logic [3:0] en_mid);
        logic [31:0] sh;
        for (int b = 0; b < 4; b++) begin
            sh = w >> (8 * (3 - b));
            chk({tag, " valid"}, valid_out, 1);
            chk({tag, " data"},  Data_out,  sh[7:0]);
            chk({tag, " sof"},   sof,       (b == 0) ? 1 : 0);
            chk({tag, " lane"},  lane_id,   g);
            chk({tag, " count"}, word_count, cnt);
            if (b == 1) port_en = en_mid;
            if (b == 3) begin
                #1;
                chk({tag, " ready"}, ready_out, next_ready);
                if (stop) valid_in = '0;
            end
            tick();
        end
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 4'b0001;
        port_en  = 4'b1111;
        Data_in  = '0;
        Data_in[31:0] = 32'hA1B2C3D4;

        // Reset state, with a requester already asking
        tick();
        tick();
        #1;
        chk("rst valid", valid_out, 0);
        chk("rst data",  Data_out,  0);
        chk("rst sof",   sof,       0);
        chk("rst lane",  lane_id,   0);
        chk("rst count", word_count, 0);
        chk("rst ready", ready_out, 0);

        // Single word
        reset = 1'b0;
        #1;
        chk("single ready", ready_out, 4'b0001);
        tick();
        valid_in = '0;
        send_word("single", 0, 32'hA1B2C3D4, 4'd1, 4'b0000, 1'b1, 4'b1111);
        chk("single idle valid", valid_out, 0);
        chk("single idle data",  Data_out,  0);
        chk("single idle sof",   sof,       0);

        // All four requesters continuously valid
        do_reset();
        Data_in  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        valid_in = 4'b1111;
        #1;
        chk("all ready0", ready_out, 4'b0001);
        tick();
        send_word("all w0", 0, 32'h11111111, 4'd1, 4'b0010, 1'b0, 4'b1111);
        send_word("all w1", 1, 32'h22222222, 4'd2, 4'b0100, 1'b0, 4'b1111);
        send_word("all w2", 2, 32'h33333333, 4'd3, 4'b1000, 1'b0, 4'b1111);
        send_word("all w3", 3, 32'h44444444, 4'd4, 4'b0001, 1'b0, 4'b1111);
        send_word("all w4", 0, 32'h11111111, 4'd5, 4'b0010, 1'b1, 4'b1111);
        chk("all drained", valid_out, 0);

        // Masking requester 2, then requester 0 while its word is in flight
        do_reset();
        port_en  = 4'b1011;
        valid_in = 4'b1111;
        #1;
        chk("mask ready0", ready_out, 4'b0001);
        tick();
        send_word("mask w0", 0, 32'h11111111, 4'd1, 4'b0010, 1'b0, 4'b1011);
        send_word("mask w1", 1, 32'h22222222, 4'd2, 4'b1000, 1'b0, 4'b1011);
        send_word("mask w3", 3, 32'h44444444, 4'd3, 4'b0001, 1'b0, 4'b1011);
        send_word("mask w0b", 0, 32'h11111111, 4'd4, 4'b0010, 1'b1, 4'b1010);
        chk("mask drained", valid_out, 0);

        // Reset after byte B2
        port_en  = 4'b1111;
        do_reset();
        Data_in[31:0] = 32'hA1B2C3D4;
        valid_in = 4'b0001;
        #1;
        chk("midrst ready", ready_out, 4'b0001);
        tick();
        valid_in = '0;
        chk("midrst A1", Data_out, 8'hA1);
        tick();
        chk("midrst B2", Data_out, 8'hB2);
        reset    = 1'b1;
        valid_in = 4'b0001;
        #1;
        chk("midrst ready in reset", ready_out, 0);
        tick();
        chk("midrst valid", valid_out, 0);
        chk("midrst data",  Data_out,  0);
        chk("midrst count", word_count, 0);
        valid_in = '0;
        reset    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst no residual", valid_out, 0);
        end

        // Counter wrap at CNT_W=4 with one lone requester (regranted without bubble)
        do_reset();
        port_en  = 4'b0001;
        valid_in = 4'b0001;
        #1;
        chk("wrap ready", ready_out, 4'b0001);
        tick();
        for (int n = 1; n <= 17; n++) begin
            send_word("wrap", 0, 32'hA1B2C3D4, 4'(n), 4'b0001, (n == 17), 4'b0001);
        end
        chk("wrap idle", valid_out, 0);
        chk("wrap count", word_count, 4'd1);

        // Sparse requester 1: one word every 10 cycles
        do_reset();
        port_en = 4'b1111;
        Data_in[63:32] = 32'hCAFEF00D;
        for (int k = 1; k <= 3; k++) begin
            chk("gap present valid", valid_out, 0);
            valid_in = 4'b0010;
            #1;
            chk("gap ready", ready_out, 4'b0010);
            tick();
            valid_in = '0;
            send_word("gap", 1, 32'hCAFEF00D, 4'(k), 4'b0000, 1'b1, 4'b1111);
            for (int i = 0; i < 5; i++) begin
                chk("gap idle valid", valid_out, 0);
                chk("gap idle ready", ready_out, 0);
                chk("gap idle data",  Data_out,  0);
                chk("gap idle sof",   sof,       0);
                chk("gap idle lane",  lane_id,   1);
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_word_lane_scheduler
`default_nettype wire
